// File: rtl/sigmf_arbiter.sv
// sigmf_arbiter: shares one piecewise-linear sigmoid (Q8.16) among NREQ
// requesters. Round-robin arbitration feeds a two-stage registered pipeline
// (s1 operand register, output register) with a tagged, backpressured result.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_data          operands, requester k at [k*WIDTH +: WIDTH]
//   out_valid/ready   result handshake
//   out_data, out_id  sigmoid result and issuing requester index
//   busy              either pipeline stage holds data
module sigmf_arbiter #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  localparam int unsigned FRAC = 16;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1 << FRAC);
  localparam logic [WIDTH-1:0] HALF = WIDTH'(1 << (FRAC - 1));
  // 0.6 in Q8.16, intercept of the slope-1/8 segment
  localparam logic [WIDTH-1:0] C06  = WIDTH'(32'h0000_9999);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [IDW-1:0]   r_s1_id;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [IDW-1:0]   r_out_id;

  logic             w_out_en;
  logic             w_s1_adv;
  logic             w_in_en;
  logic             w_grant;
  logic [IDW-1:0]   w_grant_id;
  logic [IDW-1:0]   w_next_ptr;
  logic [WIDTH-1:0] w_sig;

  // Sigmoid of a non-negative magnitude is the minimum of the three concave
  // segments (0.5 + a/4, 0.6 + a/8, 1.0); negative inputs use 1 - f(|x|).
  function automatic logic [WIDTH-1:0] sigmf(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] l1;
    logic [WIDTH-1:0] l2;
    logic [WIDTH-1:0] f;
    a  = x[WIDTH-1] ? WIDTH'(-x) : x;
    l1 = HALF + (a >> 2);
    l2 = C06 + (a >> 3);
    f  = (l1 < l2) ? l1 : l2;
    if (f > ONE) f = ONE;
    return x[WIDTH-1] ? WIDTH'(ONE - f) : f;
  endfunction

  assign w_out_en = !r_out_valid || out_ready;
  assign w_s1_adv = r_s1_valid && w_out_en;
  assign w_in_en  = !r_s1_valid || w_s1_adv;
  assign w_sig    = sigmf(r_s1_data);

  // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ
  always_comb begin
    w_grant    = 1'b0;
    w_grant_id = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      int unsigned j;
      j = int'(r_rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_grant && req_valid[j]) begin
        w_grant    = 1'b1;
        w_grant_id = IDW'(j);
      end
    end
  end

  assign w_next_ptr = (int'(w_grant_id) == int'(NREQ) - 1) ? '0 : IDW'(w_grant_id + 1'b1);

  always_comb begin
    req_ready = '0;
    if (w_in_en && w_grant && !rst) req_ready[w_grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_id     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else begin
      // Stage 1: accept the granted operand or drain when it advances
      if (w_in_en && w_grant) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= req_data[w_grant_id*WIDTH +: WIDTH];
        r_s1_id    <= w_grant_id;
        r_rr_ptr   <= w_next_ptr;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      // Stage 2: register the sigmoid; a handshake with nothing new clears it
      if (w_s1_adv) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sig;
        r_out_id    <= r_s1_id;
      end else if (w_out_en) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = r_s1_valid || r_out_valid;

endmodule
